rtc_bus_scheduler: RTL and testbench
====================================

# rtc_bus_scheduler

Transaction scheduler that sits between the clock/stopwatch control logic and the RTC bus-protocol engine (the block that toggles CS/RD/WR/A-D on the multiplexed 8-bit RTC bus). It shares the single RTC bus among three requesters: a stopwatch-enable pulse, user edit writes, and a periodic refresh sweep that reads the six time/date registers. Read results are captured into holding registers that feed the VGA display path. Exactly one bus transaction is outstanding at any time.

## Interface
Parameters:
- REFRESH_DIV, 100000: clk cycles between refresh-sweep triggers (1 ms at 100 MHz).
- TIMEOUT, 255: max cycles WAIT holds for bus_done before the transaction is aborted.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- crono_req  in  1  one-cycle pulse: request the stopwatch-enable write.
- wr_req  in  1  edit-write request; level, held with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  8  RTC register address for the edit write.
- wr_data  in  8  data for the edit write (already incremented/decremented).
- wr_ack  out  1  one-cycle pulse: edit write completed or aborted.
- bus_start  out  1  one-cycle pulse: protocol engine begins a transaction.
- bus_rw  out  1  1 = read, 0 = write (same sense as the engine's machine-indicator bit).
- bus_addr  out  8  transaction address.
- bus_wdata  out  8  write data (don't-care on reads; driven 0x00).
- bus_done  in  1  one-cycle pulse from engine: transaction finished.
- bus_rdata  in  8  read data, valid in the bus_done cycle.
- seg, min, hora, dia, mes, anio  out  8 each  captured time/date registers.
- busy  out  1  high in ISSUE and WAIT.
- sweep_done  out  1  one-cycle pulse after the sixth read of a sweep.
- err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, ISSUE, WAIT. Reset -> IDLE.
- IDLE arbitration, fixed priority: crono_pend > wr_req > sweep_pend. No request -> stay IDLE.
- crono_req pulse sets crono_pend (holds until serviced; repeated pulses merge). Service = write addr 0x00, data 0x08.
- Edit write: bus_addr = wr_addr, bus_wdata = wr_data, bus_rw = 0.
- Refresh counter counts 0..REFRESH_DIV-1 continuously; on wrap sets sweep_pend with index 0. Wrap while sweep_pend already set is dropped (no queueing).
- Sweep reads in index order 0..5: 0x21->seg, 0x22->min, 0x23->hora, 0x24->dia, 0x25->mes, 0x26->anio. Arbitration re-runs between every read, so crono/edit writes preempt mid-sweep; the sweep resumes at the saved index.
- IDLE -> ISSUE on grant; bus_addr/bus_rw/bus_wdata/grant source registered on entry.
- ISSUE: bus_start = 1 for exactly one cycle -> WAIT.
- WAIT: on bus_done -> IDLE. Read: bus_rdata stored into indexed register, index increments; index 5 done -> clear sweep_pend, pulse sweep_done. Write: crono -> clear crono_pend; edit -> pulse wr_ack.
- Timeout: cycle counter in WAIT reaches TIMEOUT without bus_done -> pulse err, IDLE. Aborted edit write still pulses wr_ack; aborted crono leaves crono_pend set (retry); aborted read leaves index unchanged (retry).
- bus_done seen outside WAIT is ignored.

## Timing
- Reset values: all outputs 0, bus_addr/bus_wdata 0x00, time registers 0x00, pend flags/index/counters 0. Reset mid-transaction deasserts bus_start immediately.
- Request in IDLE at cycle N -> bus_start high at N+1 (ISSUE) -> WAIT from N+2.
- bus_addr/bus_rw/bus_wdata stable from ISSUE through the cycle bus_done is sampled.
- bus_done at cycle M: captured register / wr_ack / sweep_done / state=IDLE all visible at M+1; next bus_start no earlier than M+2.
- Minimum transaction: 3 cycles IDLE-to-IDLE with bus_done in the first WAIT cycle.
- Timeout: err pulses TIMEOUT+1 cycles after bus_start.
- crono_req coincident with a grant of another source: latched, serviced at next arbitration.

## Test plan
- Reset then idle with REFRESH_DIV=50: first bus_start at cycle 51 with addr 0x21, rw=1; engine returns 0x10..0x15 -> seg=0x10 ... anio=0x15, sweep_done pulse after the sixth done.
- wr_req addr 0x22 data 0x35 from IDLE -> bus_start next cycle, rw=0, addr 0x22, wdata 0x35; wr_ack one cycle after bus_done.
- crono_req and wr_req same cycle -> first transaction addr 0x00 data 0x08, second the edit write.
- wr_req raised after the third sweep read -> edit write issued next, sweep resumes at addr 0x24; all six registers correct.
- Engine never returns bus_done (TIMEOUT=20) -> err pulse 21 cycles after bus_start, read retried at same address.
- Assert reset during WAIT -> all outputs 0 immediately; after release no bus_start until next refresh wrap or request.

Source files
------------

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: shares the single RTC bus among stopwatch, edit
// writes and the periodic time/date refresh sweep; one transaction at a time.
module rtc_bus_scheduler #(
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       crono_req,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       busy,
    output logic       sweep_done,
    output logic       err
);

    localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {SRC_CRONO, SRC_EDIT, SRC_SWEEP} src_t;

    state_t         state, state_n;
    src_t           src, gsrc;
    logic           gnt, done_ok, tmo;
    logic           crono_pend, sweep_pend;
    logic           crono_any, edit_req, wrap;
    logic [2:0]     idx;
    logic [RCW-1:0] ref_cnt;
    logic [TW-1:0]  to_cnt;

    // a raw crono pulse competes immediately so it beats a same-cycle edit
    assign crono_any = crono_pend | crono_req;
    // mask the ack cycle so a still-high wr_req is not granted twice
    assign edit_req  = wr_req & ~wr_ack;
    assign wrap      = (ref_cnt == RCW'(REFRESH_DIV - 1));
    assign bus_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        gnt     = 1'b0;
        gsrc    = SRC_SWEEP;
        done_ok = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                gnt = crono_any | edit_req | sweep_pend;
                if (crono_any)     gsrc = SRC_CRONO;
                else if (edit_req) gsrc = SRC_EDIT;
                if (gnt) state_n = ISSUE;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (bus_done) begin
                    done_ok = 1'b1;
                    state_n = IDLE;
                end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src        <= SRC_CRONO;
            crono_pend <= 1'b0;
            sweep_pend <= 1'b0;
            idx        <= '0;
            ref_cnt    <= '0;
            to_cnt     <= '0;
            bus_rw     <= 1'b0;
            bus_addr   <= 8'h00;
            bus_wdata  <= 8'h00;
            wr_ack     <= 1'b0;
            sweep_done <= 1'b0;
            err        <= 1'b0;
            seg        <= 8'h00;
            min        <= 8'h00;
            hora       <= 8'h00;
            dia        <= 8'h00;
            mes        <= 8'h00;
            anio       <= 8'h00;
        end else begin
            wr_ack     <= 1'b0;
            sweep_done <= 1'b0;
            err        <= tmo;
            crono_pend <= ((done_ok && src == SRC_CRONO) ? 1'b0 : crono_pend)
                          | crono_req;
            ref_cnt    <= wrap ? '0 : ref_cnt + RCW'(1);
            to_cnt     <= (state == WAIT) ? to_cnt + TW'(1) : '0;

            if (gnt) begin
                src <= gsrc;
                unique case (gsrc)
                    SRC_CRONO: begin
                        bus_rw    <= 1'b0;
                        bus_addr  <= 8'h00;
                        bus_wdata <= 8'h08;
                    end
                    SRC_EDIT: begin
                        bus_rw    <= 1'b0;
                        bus_addr  <= wr_addr;
                        bus_wdata <= wr_data;
                    end
                    default: begin
                        bus_rw    <= 1'b1;
                        bus_addr  <= 8'h21 + {5'b0, idx};
                        bus_wdata <= 8'h00;
                    end
                endcase
            end

            if ((done_ok || tmo) && src == SRC_EDIT) wr_ack <= 1'b1;

            if (done_ok && src == SRC_SWEEP) begin
                unique case (idx)
                    3'd0:    seg  <= bus_rdata;
                    3'd1:    min  <= bus_rdata;
                    3'd2:    hora <= bus_rdata;
                    3'd3:    dia  <= bus_rdata;
                    3'd4:    mes  <= bus_rdata;
                    3'd5:    anio <= bus_rdata;
                    default: ;
                endcase
                if (idx == 3'd5) begin
                    sweep_pend <= 1'b0;
                    sweep_done <= 1'b1;
                    idx        <= '0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else if (wrap && !sweep_pend) begin
                sweep_pend <= 1'b1;
                idx        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler: directed bench for rtc_bus_scheduler with
// REFRESH_DIV=50 and TIMEOUT=20; a small engine stub answers bus_start.
module tb_rtc_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       crono_req = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       bus_start, bus_rw;
    logic [7:0] bus_addr, bus_wdata;
    logic       bus_done = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic [7:0] seg, min, hora, dia, mes, anio;
    logic       busy, sweep_done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rtc_bus_scheduler #(.REFRESH_DIV(50), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset),
        .crono_req(crono_req), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .bus_start(bus_start), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_done(bus_done), .bus_rdata(bus_rdata),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .busy(busy), .sweep_done(sweep_done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // waits (bounded) for bus_start; exp_n < 0 skips the latency check
    task automatic wait_start(input string tag, input int exp_n);
        int n = 0;
        while (!bus_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".start"}, 32'(bus_start), 32'd1);
        if (exp_n >= 0) chk({tag, ".lat"}, n, exp_n);
    endtask

    task automatic xfer(input string tag, input int exp_n,
                        input logic [7:0] a, input logic rw,
                        input logic [7:0] wd, input logic [7:0] rd);
        wait_start(tag, exp_n);
        chk({tag, ".addr"}, 32'(bus_addr), 32'(a));
        chk({tag, ".rw"}, 32'(bus_rw), 32'(rw));
        chk({tag, ".wdata"}, 32'(bus_wdata), 32'(wd));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        bus_done  = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".nostart"}, 32'(bus_start), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.start", 32'(bus_start), 32'd0);
        chk("rst.addr", 32'(bus_addr), 32'd0);
        chk("rst.seg", 32'(seg), 32'd0);
        reset = 1'b0;

        // first sweep: bus_start 51 cycles after release
        xfer("sw1.0", 51, 8'h21, 1'b1, 8'h00, 8'h10);
        for (int i = 1; i < 6; i++) begin
            xfer($sformatf("sw1.%0d", i), 1, 8'(8'h21 + i), 1'b1, 8'h00,
                 8'(8'h10 + i));
            chk($sformatf("sw1.done%0d", i), 32'(sweep_done),
                32'(i == 5));
        end
        chk("sw1.seg", 32'(seg), 32'h10);
        chk("sw1.min", 32'(min), 32'h11);
        chk("sw1.hora", 32'(hora), 32'h12);
        chk("sw1.dia", 32'(dia), 32'h13);
        chk("sw1.mes", 32'(mes), 32'h14);
        chk("sw1.anio", 32'(anio), 32'h15);

        // plain edit write
        wr_req  = 1'b1;
        wr_addr = 8'h22;
        wr_data = 8'h35;
        xfer("ed1", 1, 8'h22, 1'b0, 8'h35, 8'h00);
        chk("ed1.ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("ed1.ack1", 32'(wr_ack), 32'd0);
        chk("ed1.nodup", 32'(bus_start), 32'd0);

        // crono and edit in the same cycle: crono first
        crono_req = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 8'h05;
        wr_data   = 8'h12;
        @(negedge clk);
        crono_req = 1'b0;
        xfer("cr", 0, 8'h00, 1'b0, 8'h08, 8'h00);
        chk("cr.noack", 32'(wr_ack), 32'd0);
        xfer("ed2", 1, 8'h05, 1'b0, 8'h12, 8'h00);
        chk("ed2.ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;

        // second sweep with an edit preempting after read 3
        xfer("sw2.0", 23, 8'h21, 1'b1, 8'h00, 8'h20);
        xfer("sw2.1", 1, 8'h22, 1'b1, 8'h00, 8'h21);
        xfer("sw2.2", 1, 8'h23, 1'b1, 8'h00, 8'h22);
        wr_req  = 1'b1;
        wr_addr = 8'h23;
        wr_data = 8'h44;
        xfer("ed3", 1, 8'h23, 1'b0, 8'h44, 8'h00);
        chk("ed3.ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        xfer("sw2.3", 1, 8'h24, 1'b1, 8'h00, 8'h23);
        xfer("sw2.4", 1, 8'h25, 1'b1, 8'h00, 8'h24);
        xfer("sw2.5", 1, 8'h26, 1'b1, 8'h00, 8'h25);
        chk("sw2.done", 32'(sweep_done), 32'd1);
        chk("sw2.regs", {seg, min, hora, dia}, 32'h20212223);
        chk("sw2.regs2", {16'h0, mes, anio}, 32'h00002425);

        // timeout on the first read, then retry the same address
        wait_start("to", 30);
        chk("to.addr", 32'(bus_addr), 32'h21);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!err && n < 100);
            chk("to.err", 32'(err), 32'd1);
            chk("to.lat", n, 21);
            chk("to.idle", 32'(busy), 32'd0);
        end
        xfer("sw3.0", 1, 8'h21, 1'b1, 8'h00, 8'h30);
        for (int i = 1; i < 6; i++)
            xfer($sformatf("sw3.%0d", i), 1, 8'(8'h21 + i), 1'b1, 8'h00,
                 8'(8'h30 + i));
        chk("sw3.done", 32'(sweep_done), 32'd1);
        chk("sw3.anio", 32'(anio), 32'h35);

        // stray bus_done while idle changes nothing
        bus_done  = 1'b1;
        bus_rdata = 8'hEE;
        @(negedge clk);
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        @(negedge clk);
        chk("stray.seg", 32'(seg), 32'h30);
        chk("stray.busy", 32'(busy), 32'd0);

        // reset in WAIT
        wait_start("rw", -1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw.start", 32'(bus_start), 32'd0);
        chk("rw.busy", 32'(busy), 32'd0);
        chk("rw.addr", 32'(bus_addr), 32'd0);
        chk("rw.regs", {seg, min, hora, anio}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_start("rw.re", 51);
        chk("rw.readdr", 32'(bus_addr), 32'h21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
